// File: rtl/draw_ball_if.sv
// VGA pixel stream bundle passed between PONG pipeline stages.
// Carries the raster position, sync/blank flags and the pixel colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ball.sv
// PONG ball stage: moves the ball once per frame, bounces it off walls and paddles,
// reports goals and overlays the ball on the incoming VGA stream with one cycle of latency.
module draw_ball #(
   parameter int unsigned HOR_PIX     = 800,
   parameter int unsigned VER_PIX     = 600,
   parameter int unsigned SIZE        = 10,
   parameter int unsigned STEP        = 4,
   parameter int unsigned LPAD_X      = 30,
   parameter int unsigned RPAD_X      = 750,
   parameter int unsigned PAD_W       = 20,
   parameter int unsigned PAD_H       = 100,
   parameter int unsigned HOLD_FRAMES = 60,
   parameter logic [11:0] BALL_COLOR  = 12'hff0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        serve_i,
   input  logic [10:0] paddle_l_y_i,
   input  logic [10:0] paddle_r_y_i,
   vga_if.in           vga_i,
   vga_if.out          vga_o,
   output logic [10:0] ball_x_o,
   output logic [10:0] ball_y_o,
   output logic        score_l_o,
   output logic        score_r_o
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StPlay   = 2'd1;
   localparam logic [1:0] StScored = 2'd2;

   localparam int unsigned CntW = $clog2(HOLD_FRAMES + 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_FRAMES - 1);

   localparam logic [11:0] Hor12  = 12'(HOR_PIX);
   localparam logic [11:0] Ver12  = 12'(VER_PIX);
   localparam logic [11:0] Size12 = 12'(SIZE);
   localparam logic [11:0] SizeM1 = 12'(SIZE - 1);
   localparam logic [11:0] Step12 = 12'(STEP);
   localparam logic [11:0] PadH12 = 12'(PAD_H);
   localparam logic [11:0] LEdge  = 12'(LPAD_X + PAD_W);
   localparam logic [11:0] REdge  = 12'(RPAD_X);
   localparam logic [10:0] LBnc   = 11'(LPAD_X + PAD_W + 1);
   localparam logic [10:0] RBnc   = 11'(RPAD_X - SIZE);
   localparam logic [10:0] XMax   = 11'(HOR_PIX - SIZE);
   localparam logic [10:0] YMax   = 11'(VER_PIX - SIZE);
   localparam logic [10:0] CtrX   = 11'((HOR_PIX - SIZE) / 2);
   localparam logic [10:0] CtrY   = 11'((VER_PIX - SIZE) / 2);

   logic [1:0]      state_q, state_d;
   logic [10:0]     bx_q, bx_d, by_q, by_d;
   logic            dx_q, dx_d, dy_q, dy_d;
   logic            serve_req_q, serve_req_d;
   logic [CntW-1:0] hold_q, hold_d;
   logic            score_l_q, score_l_d, score_r_q, score_r_d;
   logic            vblnk_q;

   logic        tick;
   logic [11:0] bx_w, by_w, pl_w, pr_w, hc_w, vc_w;
   logic        ovl_l, ovl_r, hit;

   assign tick = vga_i.vblnk & ~vblnk_q;
   assign bx_w = {1'b0, bx_q};
   assign by_w = {1'b0, by_q};
   assign pl_w = {1'b0, paddle_l_y_i};
   assign pr_w = {1'b0, paddle_r_y_i};
   assign hc_w = {1'b0, vga_i.hcount};
   assign vc_w = {1'b0, vga_i.vcount};

   // Overlap uses the Y position from before this tick's update.
   assign ovl_l = (by_w + SizeM1 >= pl_w) && (by_w <= pl_w + PadH12);
   assign ovl_r = (by_w + SizeM1 >= pr_w) && (by_w <= pr_w + PadH12);

   assign hit = (state_q != StScored) &&
                (hc_w >= bx_w) && (hc_w <= bx_w + SizeM1) &&
                (vc_w >= by_w) && (vc_w <= by_w + SizeM1) &&
                !vga_i.hblnk && !vga_i.vblnk;

   always_comb begin
      state_d     = state_q;
      bx_d        = bx_q;
      by_d        = by_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      serve_req_d = serve_req_q;
      hold_d      = hold_q;
      score_l_d   = 1'b0;
      score_r_d   = 1'b0;

      if ((state_q == StIdle) && serve_i) serve_req_d = 1'b1;

      if (tick) begin
         case (state_q)
            StIdle: begin
               if (serve_req_q) begin
                  state_d     = StPlay;
                  serve_req_d = 1'b0;
               end
            end
            StPlay: begin
               if (dy_q) begin
                  if (by_w + Size12 + Step12 >= Ver12) begin
                     by_d = YMax;
                     dy_d = 1'b0;
                  end else begin
                     by_d = 11'(by_w + Step12);
                  end
               end else begin
                  if (by_w <= Step12) begin
                     by_d = '0;
                     dy_d = 1'b1;
                  end else begin
                     by_d = 11'(by_w - Step12);
                  end
               end

               // Bounce only when this step crosses the paddle face; a ball already
               // behind the paddle keeps going to the wall.
               if (!dx_q) begin
                  if ((bx_w > LEdge) && (bx_w <= LEdge + Step12) && ovl_l) begin
                     bx_d = LBnc;
                     dx_d = 1'b1;
                  end else if (bx_w <= Step12) begin
                     bx_d      = '0;
                     dx_d      = 1'b0;
                     score_r_d = 1'b1;
                     state_d   = StScored;
                  end else begin
                     bx_d = 11'(bx_w - Step12);
                  end
               end else begin
                  if ((bx_w + Size12 <= REdge) && (bx_w + Size12 + Step12 > REdge) && ovl_r) begin
                     bx_d = RBnc;
                     dx_d = 1'b0;
                  end else if (bx_w + Size12 + Step12 >= Hor12) begin
                     bx_d      = XMax;
                     dx_d      = 1'b1;
                     score_l_d = 1'b1;
                     state_d   = StScored;
                  end else begin
                     bx_d = 11'(bx_w + Step12);
                  end
               end
            end
            StScored: begin
               if (hold_q == HoldLast) begin
                  bx_d    = CtrX;
                  by_d    = CtrY;
                  dy_d    = 1'b1;
                  hold_d  = '0;
                  state_d = StIdle;
               end else begin
                  hold_d = hold_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         bx_q         <= CtrX;
         by_q         <= CtrY;
         dx_q         <= 1'b1;
         dy_q         <= 1'b1;
         serve_req_q  <= 1'b0;
         hold_q       <= '0;
         score_l_q    <= 1'b0;
         score_r_q    <= 1'b0;
         vblnk_q      <= 1'b0;
         vga_o.hcount <= '0;
         vga_o.vcount <= '0;
         vga_o.hsync  <= 1'b0;
         vga_o.vsync  <= 1'b0;
         vga_o.hblnk  <= 1'b0;
         vga_o.vblnk  <= 1'b0;
         vga_o.rgb    <= '0;
      end else begin
         state_q      <= state_d;
         bx_q         <= bx_d;
         by_q         <= by_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         serve_req_q  <= serve_req_d;
         hold_q       <= hold_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         vblnk_q      <= vga_i.vblnk;
         vga_o.hcount <= vga_i.hcount;
         vga_o.vcount <= vga_i.vcount;
         vga_o.hsync  <= vga_i.hsync;
         vga_o.vsync  <= vga_i.vsync;
         vga_o.hblnk  <= vga_i.hblnk;
         vga_o.vblnk  <= vga_i.vblnk;
         vga_o.rgb    <= hit ? BALL_COLOR : vga_i.rgb;
      end
   end

   assign ball_x_o  = bx_q;
   assign ball_y_o  = by_q;
   assign score_l_o = score_l_q;
   assign score_r_o = score_r_q;

endmodule

// File: doc/draw_ball.md
# draw_ball

Ball stage of the PONG pixel pipeline. It sits directly downstream of the paddle drawer: it consumes that stage's VGA stream and the paddle Y positions. It moves a square ball once per frame, bounces it off the top/bottom walls and paddles, and reports goals. It overlays the ball on the incoming `rgb` with one cycle of latency.

## Interface
Parameters:
- `HOR_PIX`, 800: visible width.
- `VER_PIX`, 600: visible height.
- `SIZE`, 10: ball edge length in pixels.
- `STEP`, 4: pixels moved per frame on each axis.
- `LPAD_X`, 30: left paddle left edge.
- `RPAD_X`, 750: right paddle left edge.
- `PAD_W`, 20: paddle width; occupied columns are X..X+PAD_W inclusive.
- `PAD_H`, 100: paddle height; occupied rows are y..y+PAD_H inclusive.
- `HOLD_FRAMES`, 60: frames the ball stays hidden after a goal.
- `BALL_COLOR`, 12'hf_f_0: ball colour.

Ports:
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous, active-high reset.
- `serve`  in  1: level request to launch the ball.
- `paddle_l_y`  in  11: left paddle top row.
- `paddle_r_y`  in  11: right paddle top row.
- `vga`  vga_if.in: upstream hcount/vcount (11 b), hsync, vsync, hblnk, vblnk, rgb (12 b).
- `vga_out`  vga_if.out: same fields, delayed one cycle, with the ball overlaid.
- `ball_x`  out  11: ball left column, registered.
- `ball_y`  out  11: ball top row, registered.
- `score_l`  out  1: one-cycle pulse when the left player scores (ball reached the right wall).
- `score_r`  out  1: one-cycle pulse when the right player scores (ball reached the left wall).

## Operation
- Frame tick: `tick = vga.vblnk & ~vblnk_d`, where `vblnk_d` is `vga.vblnk` registered. All motion and FSM updates happen only on a tick cycle.
- Direction registers: `dx` (1 = right), `dy` (1 = down).
- FSM states:
  - IDLE: ball centred and drawn. A `serve` high on any cycle sets `serve_req`. On a tick with `serve_req` set: go to PLAY and clear `serve_req`. No motion on that tick.
  - PLAY: on each tick, X and Y update independently.
    - Y up: if `ball_y <= STEP`, then `ball_y = 0` and `dy = 1`. Otherwise `ball_y -= STEP`.
    - Y down: if `ball_y + SIZE + STEP >= VER_PIX`, then `ball_y = VER_PIX - SIZE` and `dy = 0`. Otherwise `ball_y += STEP`.
    - Left paddle overlap (`ovl_l`): `ball_y + SIZE - 1 >= paddle_l_y` and `ball_y <= paddle_l_y + PAD_H`. `ovl_r` is the same test with `paddle_r_y`.
    - X left, checks in priority order:
      1. If `ball_x > LPAD_X+PAD_W`, `ball_x - STEP <= LPAD_X+PAD_W` and `ovl_l`: `ball_x = LPAD_X+PAD_W+1`, `dx = 1`.
      2. Else if `ball_x <= STEP`: `ball_x = 0`, pulse `score_r`, go to SCORED.
      3. Else `ball_x -= STEP`.
    - X right, checks in priority order:
      1. If `ball_x+SIZE-1 < RPAD_X`, `ball_x+SIZE-1+STEP >= RPAD_X` and `ovl_r`: `ball_x = RPAD_X - SIZE`, `dx = 0`.
      2. Else if `ball_x + SIZE + STEP >= HOR_PIX`: `ball_x = HOR_PIX - SIZE`, pulse `score_l`, go to SCORED.
      3. Else `ball_x += STEP`.
    - Paddle tests use Y values from before this tick's update.
    - A ball already behind a paddle never bounces.
  - SCORED: ball hidden and frozen. The frame counter increments on each tick. On the tick where the counter reaches `HOLD_FRAMES`, all of the following happen:
    - ball re-centres;
    - `dx` points toward the player who conceded (after `score_r`, `dx = 0`; after `score_l`, `dx = 1`);
    - `dy = 1`;
    - counter clears;
    - FSM goes to IDLE.
- Arithmetic: all comparisons are 12-bit unsigned. No subtraction happens unless the guarding compare rules out underflow.
- Draw: `vga_out.rgb <= BALL_COLOR` when the state is not SCORED and all of the following hold:
  - `vga.hcount` in `[ball_x, ball_x+SIZE-1]`;
  - `vga.vcount` in `[ball_y, ball_y+SIZE-1]`;
  - `vga.hblnk` and `vga.vblnk` are both low.
  Otherwise `vga_out.rgb <= vga.rgb`.
- Reset values:
  - all `vga_out` fields 0;
  - `ball_x = (HOR_PIX-SIZE)/2 = 395`, `ball_y = (VER_PIX-SIZE)/2 = 295`;
  - `dx = 1`, `dy = 1`;
  - state IDLE;
  - `serve_req`, counter, `vblnk_d`, `score_l`, `score_r` all 0.

## Timing
- `vga_out` is every input field registered once: exactly 1-cycle latency, no bubbles.
- `ball_x`, `ball_y`, `dx`, `dy`, the state and the score pulses all change on the clock edge that samples `tick` = 1.
- Score pulses are exactly one cycle wide.
- The position changes only in vertical blank, so a frame never tears.
- `rst` mid-operation returns every register to its reset value on the next edge, including a pending serve or a hold in progress.
- `serve` held continuously produces exactly one IDLE→PLAY launch per IDLE entry.

## Test plan
- Reset, then 3 frames with no serve: `ball_x = 395`, `ball_y = 295`, no score pulses, and the ball is drawn at hcount 395..404, vcount 295..304 one cycle later.
- Pulse `serve` for 1 cycle mid-frame: PLAY entered at the next tick; on the following tick `ball_x = 399`, `ball_y = 299`.
- Force `ball_y = 2`, `dy = 0` in PLAY: next tick `ball_y = 0`, `dy = 1`; the tick after that `ball_y = 4`.
- `ball_x = 53`, `dx = 0`, `ball_y = 200`, `paddle_l_y = 150`: next tick `ball_x = 51`, `dx = 1`, no score. Repeat with `paddle_l_y = 400`: `ball_x = 49`; subsequent ticks continue down to `ball_x = 0` with a single `score_r` pulse. The ball is hidden for 60 frames, then re-centred in IDLE with `dx = 0`.
- Right side at `ball_x = 738`, `dx = 1`, overlap: `ball_x = 740`, `dx = 0`. Without overlap, the ball runs on until `ball_x = 790` with one `score_l` pulse.
- Assert `rst` for 1 cycle during SCORED frame 30: all outputs return to reset values, and the next serve launches normally.
